// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state type, width helpers and set-count clamp for the systolic sequencer
package systolic_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT1, ROLL, DONE} seq_state_t;

  // Width of an index over n values; never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cyc_w(input int fill_lat, input int rows, input int sets);
    return $clog2(fill_lat + rows * sets + 1);
  endfunction

  localparam int DEF_ROWS_PER_SET = 64;
  localparam int DEF_MAX_SETS     = 4;
  localparam int DEF_IDX_W        = idx_w(DEF_ROWS_PER_SET);
  localparam int DEF_SET_W        = idx_w(DEF_MAX_SETS);
  localparam int DEF_CYC_W        = cyc_w(33, DEF_ROWS_PER_SET, DEF_MAX_SETS);

  // A request for zero sets runs one; oversize requests run the maximum
  function automatic int clamp_sets(input int cfg, input int max_sets);
    if (cfg == 0) return 1;
    if (cfg > max_sets) return max_sets;
    return cfg;
  endfunction

endpackage

// File: rtl/systolic_row_counter.sv
// rtl/systolic_row_counter.sv - enabled row/set wrap counter with terminal flag
module systolic_row_counter
  import systolic_pkg::*;
#(
  parameter int ROWS = 64,
  parameter int SETS = 4,
  localparam int IW  = idx_w(ROWS),
  localparam int SW  = idx_w(SETS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [SW-1:0] last_set,
  output logic [IW-1:0] matrix_index,
  output logic [SW-1:0] data_set,
  output logic          terminal
);

  logic row_last;

  assign row_last = (matrix_index == IW'(ROWS - 1));
  assign terminal = en && row_last && (data_set == last_set);

  // The final row is left in place so the last written position stays visible
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      matrix_index <= '0;
      data_set     <= '0;
    end else if (en && !terminal) begin
      if (row_last) begin
        matrix_index <= '0;
        data_set     <= data_set + SW'(1);
      end else begin
        matrix_index <= matrix_index + IW'(1);
      end
    end
  end

endmodule

// File: rtl/systolic_seq_controller.sv
// rtl/systolic_seq_controller.sv - N x N systolic array sequencer; optional abort via SYSTOLIC_SEQ_ABORT_EN
module systolic_seq_controller
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE   = 32,
  parameter int ROWS_PER_SET = 64,
  parameter int MAX_SETS     = 4,
  parameter int ADDR_W       = 7,
  parameter int FILL_LAT     = ARRAY_SIZE + 1,
  parameter int CYC_W        = $clog2(FILL_LAT + ROWS_PER_SET * MAX_SETS + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [$clog2(MAX_SETS):0]      cfg_num_sets,
  input  logic                           stall,
  input  logic                           abort,
  output logic                           alu_en,
  output logic                           sram_write_enable,
  output logic [ADDR_W-1:0]              addr_serial_num,
  output logic [CYC_W-1:0]               cycle_num,
  output logic [idx_w(ROWS_PER_SET)-1:0] matrix_index,
  output logic [idx_w(MAX_SETS)-1:0]     data_set,
  output logic                           busy,
  output logic                           done
);

  localparam int SW = idx_w(MAX_SETS);

  seq_state_t    state;
  logic [SW-1:0] last_set;
  logic          accept;
  logic          advance;
  logic          write;
  logic          terminal;
  logic          abort_hit;

`ifdef SYSTOLIC_SEQ_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  assign accept  = (state == IDLE) && start;
  assign advance = (state == ROLL) && !stall;
  assign write   = advance && (cycle_num >= CYC_W'(FILL_LAT));

  // Abort gates the strobes in the same cycle it is seen
  assign alu_en            = advance && !abort_hit;
  assign sram_write_enable = write && !abort_hit;
  assign done              = (state == DONE) && !abort_hit;
  assign busy              = (state != IDLE);

  systolic_row_counter #(
    .ROWS (ROWS_PER_SET),
    .SETS (MAX_SETS)
  ) u_row_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (accept || abort_hit),
    .en           (sram_write_enable),
    .last_set     (last_set),
    .matrix_index (matrix_index),
    .data_set     (data_set),
    .terminal     (terminal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      addr_serial_num <= '0;
      cycle_num       <= '0;
      last_set        <= '0;
    end else if (abort_hit) begin
      state           <= IDLE;
      addr_serial_num <= '0;
      cycle_num       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state           <= LOAD;
          addr_serial_num <= '0;
          cycle_num       <= '0;
          last_set        <= SW'(clamp_sets(int'(cfg_num_sets), MAX_SETS) - 1);
        end
        LOAD: begin
          state           <= WAIT1;
          addr_serial_num <= ADDR_W'(1);
        end
        WAIT1: begin
          state           <= ROLL;
          addr_serial_num <= ADDR_W'(2);
          cycle_num       <= '0;
        end
        ROLL: if (advance) begin
          if (cycle_num != '1) cycle_num <= cycle_num + CYC_W'(1);
          if (addr_serial_num != '1) addr_serial_num <= addr_serial_num + ADDR_W'(1);
          if (terminal) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_seq_controller.sv
// tb/tb_systolic_seq_controller.sv - self-checking bench for systolic_seq_controller
module tb_systolic_seq_controller;

  logic       clk = 1'b0;
  logic       rst_n, start, stall, abort;
  logic [2:0] cfg_num_sets;
  logic       alu_en, sram_write_enable, busy, done;
  logic [6:0] addr_serial_num;
  logic [8:0] cycle_num;
  logic [5:0] matrix_index;
  logic [1:0] data_set;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  typedef struct {
    string name;
    int    cfg;
    int    stall_len;
    bit    repulse;
    int    exp_sets;
    int    exp_first;
    int    exp_done;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  systolic_seq_controller dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .cfg_num_sets      (cfg_num_sets),
    .stall             (stall),
    .abort             (abort),
    .alu_en            (alu_en),
    .sram_write_enable (sram_write_enable),
    .addr_serial_num   (addr_serial_num),
    .cycle_num         (cycle_num),
    .matrix_index      (matrix_index),
    .data_set          (data_set),
    .busy              (busy),
    .done              (done)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string name);
    check({name, " busy"}, busy, 0);
    check({name, " done"}, done, 0);
    check({name, " alu_en"}, alu_en, 0);
    check({name, " we"}, sram_write_enable, 0);
    check({name, " addr"}, addr_serial_num, 0);
    check({name, " cycle_num"}, cycle_num, 0);
    check({name, " matrix_index"}, matrix_index, 0);
    check({name, " data_set"}, data_set, 0);
  endtask

  // Cycle 0 is the cycle in which start is sampled; rst_at/abort_at <= 0 disable those events
  task automatic run_case(input string name, input int cfg, input int stall_len, input bit repulse,
                          input int rst_at, input int abort_at, input int exp_sets,
                          input int exp_first, input int exp_done);
    int cyc = 0;
    int writes = 0;
    int dones = 0;
    int first_w = -1;
    int last_w = -1;
    int done_cyc = -1;
    int stall_left = 0;
    bit stall_used = 0;
    bit fin = 0;
    bit early = 0;
    sb.delete();
    for (int s = 0; s < exp_sets; s++)
      for (int r = 0; r < 64; r++) sb.push_back(8'((s << 6) | r));
    @(negedge clk);
    cfg_num_sets = 3'(cfg);
    start = 1'b1;
    stall = 1'b0;
    abort = 1'b0;
    #1 check({name, " idle at start"}, busy, 0);
    while (!fin && cyc < 600) begin
      @(negedge clk);
      cyc++;
      start = repulse && (cyc == 10 || cyc == exp_done);
      if (stall_len > 0 && !stall_used && busy && cycle_num == 40) begin
        stall_used = 1;
        stall_left = stall_len;
      end
      stall = (stall_left > 0);
      rst_n = !(rst_at > 0 && cyc == rst_at);
      abort = (abort_at > 0 && cyc == abort_at);
      #1;
      if (cyc == 1) begin
        check({name, " load busy"}, busy, 1);
        check({name, " load addr"}, addr_serial_num, 0);
      end
      if (cyc == 3) begin
        check({name, " roll cycle_num"}, cycle_num, 0);
        check({name, " roll addr"}, addr_serial_num, 2);
        check({name, " roll alu_en"}, alu_en, 1);
      end
      if (stall) begin
        check({name, " stall alu_en"}, alu_en, 0);
        check({name, " stall we"}, sram_write_enable, 0);
        check({name, " stall cycle_num"}, cycle_num, 40);
        check({name, " stall addr"}, addr_serial_num, 42);
        stall_left--;
      end
      if (sram_write_enable) begin
        writes++;
        if (first_w < 0) first_w = cyc;
        last_w = cyc;
        if (sb.size() == 0) check({name, " extra write"}, writes, 64 * exp_sets);
        else check({name, " row"}, {data_set, matrix_index}, sb.pop_front());
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (rst_at > 0 && cyc == rst_at + 1) begin
        check_idle_zero({name, " after reset"});
        fin = 1;
        early = 1;
      end
`ifdef SYSTOLIC_SEQ_ABORT_EN
      if (abort_at > 0 && cyc == abort_at) begin
        check({name, " abort alu_en"}, alu_en, 0);
        check({name, " abort we"}, sram_write_enable, 0);
      end
      if (abort_at > 0 && cyc == abort_at + 1) begin
        check_idle_zero({name, " after abort"});
        check({name, " abort no done"}, dones, 0);
        fin = 1;
        early = 1;
      end
`endif
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check({name, " busy after done"}, busy, 0);
        fin = 1;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    if (!fin) begin
      check({name, " timeout"}, cyc, -1);
    end else if (!early) begin
      check({name, " done count"}, dones, 1);
      check({name, " done cycle"}, done_cyc, exp_done);
      check({name, " first write"}, first_w, exp_first);
      check({name, " last write"}, last_w, exp_done - 1);
      check({name, " writes"}, writes, 64 * exp_sets);
      check({name, " leftover rows"}, sb.size(), 0);
      check({name, " final matrix_index"}, matrix_index, 63);
      check({name, " final data_set"}, data_set, exp_sets - 1);
      if (repulse) begin
        @(negedge clk);
        #1 check({name, " stays idle"}, busy, 0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
    cfg_num_sets = 3'd0;
    repeat (3) @(negedge clk);
    #1 check_idle_zero("reset");
    rst_n = 1'b1;

    vecs[0] = '{"nominal", 2, 0, 1'b0, 2, 36, 164};
    vecs[1] = '{"sets0",   0, 0, 1'b0, 1, 36, 100};
    vecs[2] = '{"sets7",   7, 0, 1'b0, 4, 36, 292};
    vecs[3] = '{"stall5",  2, 5, 1'b0, 2, 36, 169};
    vecs[4] = '{"repulse", 2, 0, 1'b1, 2, 36, 164};
    vecs[5] = '{"sets1",   1, 0, 1'b0, 1, 36, 100};
    vecs[6] = '{"sets3",   3, 0, 1'b0, 3, 36, 228};

    for (int i = 0; i < 7; i++)
      run_case(vecs[i].name, vecs[i].cfg, vecs[i].stall_len, vecs[i].repulse, -1, -1,
               vecs[i].exp_sets, vecs[i].exp_first, vecs[i].exp_done);

    run_case("midreset", 2, 0, 1'b0, 50, -1, 2, 36, 164);
    run_case("post_reset", 2, 0, 1'b0, -1, -1, 2, 36, 164);

`ifdef SYSTOLIC_SEQ_ABORT_EN
    run_case("abort", 2, 0, 1'b0, -1, 80, 2, 36, 164);
    run_case("post_abort", 2, 0, 1'b0, -1, -1, 2, 36, 164);
`else
    run_case("abort_ignored", 2, 0, 1'b0, -1, 80, 2, 36, 164);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
